// File: rtl/nios2_oci_dct_capture_pkg.sv
// Shared definitions for the Nios II OCI data-capture-trace collector.
// Contents:
//   state_e : collector FSM states (IDLE, UNPACK, DRAIN, DONE)
//   clog2   : ceiling log2 helper used to size pointers and level counters
package nios2_oci_dct_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/nios2_oci_sync_fifo.sv
// Single-clock FIFO with a registered read-data port.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   push, wdata         : write request and data (ignored when full unless popping)
//   pop                 : read request (ignored when empty)
//   rdata               : registered head-of-queue entry, valid while !empty
//   full, empty, level  : occupancy status
module nios2_oci_sync_fifo
  import nios2_oci_dct_capture_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             push_ok, pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = rdata_q;

  // A pop frees a slot in the same cycle, so a push into a full FIFO
  // succeeds when paired with a pop. The read register always holds the
  // entry at the next read pointer; when that slot is being written this
  // cycle, the incoming word is taken directly.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
    rdata_d = rdata_q;
    if (push_ok || pop_ok) begin
      rdata_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? wdata : mem_q[rd_ptr_d];
    end
  end

  // Storage array: no reset needed, the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// Data-capture-trace collector: accepts packed multi-slot DCT buffers,
// unpacks them one entry per cycle into a FIFO, streams entries out on a
// valid/ready port, and sequences the end-of-test handshake.
// Ports:
//   clk, reset_n                   : clock, asynchronous active-low reset
//   dct_valid/dct_ready            : packed buffer handshake
//   dct_buffer, dct_count          : packed slots (slot 0 in LSBs), valid slot count
//   test_ending, test_has_ended    : end-of-test indications
//   out_valid/out_ready, out_data  : unpacked entry stream
//   fifo_level                     : FIFO occupancy
//   entry_total                    : entries pushed since reset (wraps)
//   count_err                      : sticky, a count above SLOTS was accepted
//   done                           : sticky, all data drained after test end
module nios2_oci_dct_capture
  import nios2_oci_dct_capture_pkg::*;
#(
  parameter int ENTRY_W = 10,
  parameter int SLOTS   = 3,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 16,
  parameter int TOTAL_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dct_valid,
  output logic                     dct_ready,
  input  logic [ENTRY_W*SLOTS-1:0] dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ENTRY_W-1:0]       out_data,
  output logic [clog2(DEPTH):0]    fifo_level,
  output logic [TOTAL_W-1:0]       entry_total,
  output logic                     count_err,
  output logic                     done
);

  localparam int               BUF_W   = ENTRY_W * SLOTS;
  localparam logic [CNT_W-1:0] SLOTS_C = CNT_W'(SLOTS);

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               count_err_q, count_err_d;
  logic               ending_seen_q, ending_seen_d;

  logic               fifo_push, fifo_full, fifo_empty, fifo_can_push;
  logic [ENTRY_W-1:0] slot_data;

  assign slot_data     = buf_q[int'(idx_q)*ENTRY_W +: ENTRY_W];
  // A consumer pop in the same cycle makes room even when full.
  assign fifo_can_push = !fifo_full || (out_ready && !fifo_empty);
  assign out_valid     = !fifo_empty;
  assign entry_total   = total_q;
  assign count_err     = count_err_q;
  assign done          = (state_q == ST_DONE);

  nios2_oci_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (slot_data),
    .pop     (out_ready),
    .rdata   (out_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Next-state logic. dct_ready is qualified with reset_n so the collector
  // never advertises readiness while held in reset. An acceptance in the
  // cycle test_ending first rises is still honoured because IDLE only
  // looks at the registered ending flag.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    n_d           = n_q;
    idx_d         = idx_q;
    total_d       = total_q;
    count_err_d   = count_err_q;
    ending_seen_d = ending_seen_q || test_ending || test_has_ended;
    dct_ready     = 1'b0;
    fifo_push     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ending_seen_q) begin
          state_d = ST_DRAIN;
        end else begin
          dct_ready = reset_n;
          if (dct_valid && reset_n) begin
            buf_d = dct_buffer;
            idx_d = '0;
            if (dct_count > SLOTS_C) begin
              n_d         = SLOTS_C;
              count_err_d = 1'b1;
            end else begin
              n_d = dct_count;
            end
            if (dct_count != '0) state_d = ST_UNPACK;
          end
        end
      end
      ST_UNPACK: begin
        if (fifo_can_push) begin
          fifo_push = 1'b1;
          idx_d     = idx_q + CNT_W'(1);
          total_d   = total_q + TOTAL_W'(1);
          if (idx_q == n_q - CNT_W'(1)) begin
            state_d = ending_seen_d ? ST_DRAIN : ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        if (test_has_ended && fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched buffer and statistics registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      buf_q         <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      total_q       <= '0;
      count_err_q   <= 1'b0;
      ending_seen_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      total_q       <= total_d;
      count_err_q   <= count_err_d;
      ending_seen_q <= ending_seen_d;
    end
  end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Self-checking bench for nios2_oci_dct_capture: table-driven buffer vectors,
// backpressure/full corner case, randomized traffic against a queue-based
// reference model, reset mid-unpack and end-of-test sequencing.
module tb_nios2_oci_dct_capture;

  localparam int ENTRY_W = 10;
  localparam int SLOTS   = 3;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int TOTAL_W = 32;
  localparam int BUF_W   = ENTRY_W * SLOTS;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               dct_valid;
  logic               dct_ready;
  logic [BUF_W-1:0]   dct_buffer;
  logic [CNT_W-1:0]   dct_count;
  logic               test_ending;
  logic               test_has_ended;
  logic               out_valid;
  logic               out_ready;
  logic [ENTRY_W-1:0] out_data;
  logic [LVL_W-1:0]   fifo_level;
  logic [TOTAL_W-1:0] entry_total;
  logic               count_err;
  logic               done;

  always #5 clk = ~clk;

  nios2_oci_dct_capture #(
    .ENTRY_W (ENTRY_W),
    .SLOTS   (SLOTS),
    .CNT_W   (CNT_W),
    .DEPTH   (DEPTH),
    .TOTAL_W (TOTAL_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_valid      (dct_valid),
    .dct_ready      (dct_ready),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .fifo_level     (fifo_level),
    .entry_total    (entry_total),
    .count_err      (count_err),
    .done           (done)
  );

  typedef struct {
    logic [CNT_W-1:0] count;
    logic [BUF_W-1:0] buffer;
    int               exp_pushed;
    logic             exp_err;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted buffer contributes min(count, SLOTS)
  // entries, slot 0 first, to an ordered queue of expected outputs.
  logic [ENTRY_W-1:0] exp_q[$];
  longint             model_total = 0;
  logic               model_err = 1'b0;
  logic               accepted = 1'b0;
  logic               hold_pending = 1'b0;
  logic [ENTRY_W-1:0] last_data = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic modelAccept(input logic [BUF_W-1:0] b, input logic [CNT_W-1:0] c);
    int n;
    n = (int'(c) > SLOTS) ? SLOTS : int'(c);
    if (int'(c) > SLOTS) model_err = 1'b1;
    for (int i = 0; i < n; i++) exp_q.push_back(b[i*ENTRY_W +: ENTRY_W]);
    model_total += n;
  endtask

  // One clock: observe handshakes on the falling edge, then step past the
  // next rising edge so the caller may drive new inputs.
  task automatic tick();
    @(negedge clk);
    if (hold_pending) begin
      checkOutput("out_valid_hold", {63'd0, out_valid}, 64'd1);
      checkOutput("out_data_hold", {54'd0, out_data}, {54'd0, last_data});
    end
    hold_pending = out_valid && !out_ready;
    last_data    = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) failNow("pop_unexpected");
      else checkOutput("out_data", {54'd0, out_data}, {54'd0, exp_q.pop_front()});
    end
    if (dct_valid && dct_ready) begin
      accepted = 1'b1;
      modelAccept(dct_buffer, dct_count);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [BUF_W-1:0] b, input logic [CNT_W-1:0] c);
    int guard = 0;
    dct_buffer = b;
    dct_count  = c;
    dct_valid  = 1'b1;
    accepted   = 1'b0;
    while (!accepted && guard < 500) begin
      tick();
      guard++;
    end
    dct_valid = 1'b0;
    if (!accepted) failNow("accept_timeout");
  endtask

  task automatic waitIdle(input int budget, output int busy);
    busy = 0;
    while (!dct_ready && busy < budget) begin
      busy++;
      tick();
    end
    if (!dct_ready) failNow("idle_timeout");
  endtask

  task automatic waitDrain(input int budget);
    int guard = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && guard < budget) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0 || out_valid) failNow("drain_timeout");
    checkOutput("drain_level", {59'd0, fifo_level}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy;
    int seen_empty;
    int guard;
    longint running;
    logic [CNT_W-1:0] c;

    vecs[0] = '{4'd0,  {10'h0AB, 10'h0CD, 10'h0EF}, 0, 1'b0};
    vecs[1] = '{4'd3,  {10'h3FF, 10'h155, 10'h001}, 3, 1'b0};
    vecs[2] = '{4'd1,  {10'h0AA, 10'h0BB, 10'h2CC}, 1, 1'b0};
    vecs[3] = '{4'd2,  {10'h111, 10'h222, 10'h333}, 2, 1'b0};
    vecs[4] = '{4'd7,  {10'h0F0, 10'h00F, 10'h3C3}, 3, 1'b1};
    vecs[5] = '{4'd3,  {10'h246, 10'h135, 10'h2A5}, 3, 1'b1};
    vecs[6] = '{4'd4,  {10'h3A0, 10'h05A, 10'h1E1}, 3, 1'b1};

    reset_n        = 1'b0;
    dct_valid      = 1'b0;
    dct_buffer     = '0;
    dct_count      = '0;
    test_ending    = 1'b0;
    test_has_ended = 1'b0;
    out_ready      = 1'b0;

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dct_ready", {63'd0, dct_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_data", {54'd0, out_data}, 64'd0);
    checkOutput("rst_level", {59'd0, fifo_level}, 64'd0);
    checkOutput("rst_total", {32'd0, entry_total}, 64'd0);
    checkOutput("rst_count_err", {63'd0, count_err}, 64'd0);
    checkOutput("rst_done", {63'd0, done}, 64'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("idle_ready", {63'd0, dct_ready}, 64'd1);

    // Table-driven single buffers, consumer always ready.
    running = 0;
    for (int v = 0; v < 7; v++) begin
      out_ready = 1'b1;
      applyStimulus(vecs[v].buffer, vecs[v].count);
      waitIdle(50, busy);
      checkOutput("busy_cycles", 64'(busy), 64'(vecs[v].exp_pushed));
      waitDrain(100);
      running += vecs[v].exp_pushed;
      checkOutput("vec_total", {32'd0, entry_total}, 64'(running));
      checkOutput("vec_count_err", {63'd0, count_err}, {63'd0, vecs[v].exp_err});
    end

    // Backpressure: six full buffers into a 16-deep FIFO with no consumer.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) applyStimulus(BUF_W'($urandom), 4'd3);
    repeat (10) tick();
    checkOutput("full_level", {59'd0, fifo_level}, 64'(DEPTH));
    checkOutput("full_stall_ready", {63'd0, dct_ready}, 64'd0);
    checkOutput("full_stall_total", {32'd0, entry_total}, 64'(model_total - 2));
    out_ready = 1'b1;
    tick();
    checkOutput("full_pushpop_level", {59'd0, fifo_level}, 64'(DEPTH));
    checkOutput("full_pushpop_total", {32'd0, entry_total}, 64'(model_total - 1));
    waitIdle(100, busy);
    waitDrain(200);
    checkOutput("bp_total", {32'd0, entry_total}, 64'(model_total));

    // Randomized traffic with random consumer stalls.
    for (int r = 0; r < 60; r++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) c = CNT_W'($urandom_range(4, 15));
      else c = CNT_W'($urandom_range(0, 3));
      dct_buffer = BUF_W'($urandom);
      dct_count  = c;
      dct_valid  = ($urandom_range(0, 1) == 1);
      tick();
    end
    dct_valid = 1'b0;
    out_ready = 1'b1;
    waitIdle(200, busy);
    waitDrain(400);
    checkOutput("rand_total", {32'd0, entry_total}, 64'(model_total));
    checkOutput("rand_count_err", {63'd0, count_err}, {63'd0, model_err});

    // Reset asserted while a buffer is being unpacked.
    out_ready = 1'b0;
    applyStimulus({10'h123, 10'h2BC, 10'h0DE}, 4'd3);
    tick();
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    model_total  = 0;
    model_err    = 1'b0;
    hold_pending = 1'b0;
    checkOutput("mid_rst_ready", {63'd0, dct_ready}, 64'd0);
    checkOutput("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("mid_rst_data", {54'd0, out_data}, 64'd0);
    checkOutput("mid_rst_level", {59'd0, fifo_level}, 64'd0);
    checkOutput("mid_rst_total", {32'd0, entry_total}, 64'd0);
    checkOutput("mid_rst_count_err", {63'd0, count_err}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    checkOutput("post_rst_ready", {63'd0, dct_ready}, 64'd1);
    out_ready = 1'b1;
    applyStimulus({10'h00C, 10'h00B, 10'h00A}, 4'd3);
    waitIdle(50, busy);
    waitDrain(100);
    checkOutput("post_rst_total", {32'd0, entry_total}, 64'd3);

    // End of test: ending raised mid-unpack, consumer stalled, then the
    // test ends and the consumer drains the FIFO.
    out_ready = 1'b0;
    applyStimulus({10'h301, 10'h202, 10'h103}, 4'd3);
    test_ending = 1'b1;
    dct_buffer  = {10'h3EE, 10'h3DD, 10'h3CC};
    dct_count   = 4'd3;
    dct_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("ending_ready", {63'd0, dct_ready}, 64'd0);
    end
    checkOutput("ending_level", {59'd0, fifo_level}, 64'd3);
    test_has_ended = 1'b1;
    out_ready      = 1'b1;
    seen_empty     = 0;
    guard          = 0;
    while (seen_empty == 0 && guard < 100) begin
      tick();
      guard++;
      if (fifo_level == '0) seen_empty = 1;
    end
    if (seen_empty == 0) failNow("empty_timeout");
    checkOutput("done_not_early", {63'd0, done}, 64'd0);
    tick();
    checkOutput("done_after_empty", {63'd0, done}, 64'd1);
    repeat (3) tick();
    checkOutput("done_held", {63'd0, done}, 64'd1);
    checkOutput("done_ready", {63'd0, dct_ready}, 64'd0);
    checkOutput("end_total", {32'd0, entry_total}, 64'(model_total));
    checkOutput("end_queue", 64'(exp_q.size()), 64'd0);
    dct_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
